// File: rtl/recog_match_scheduler_pkg.sv
// rtl/recog_match_scheduler_pkg.sv - shared widths, FSM state codes and distance constants
package recog_match_scheduler_pkg;

  localparam int FEAT_W = 16;
  localparam int DIST_W = 32;
  localparam int TPL_W  = 4;

  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FILL   = 3'd1;
  localparam state_t ST_START  = 3'd2;
  localparam state_t ST_STREAM = 3'd3;
  localparam state_t ST_WAIT   = 3'd4;
  localparam state_t ST_DECIDE = 3'd5;

endpackage

// File: rtl/recog_match_scheduler_if.sv
// rtl/recog_match_scheduler_if.sv - feature input and template-engine handshake bundle
interface recog_match_scheduler_if;
  import recog_match_scheduler_pkg::*;

  logic signed [FEAT_W-1:0] feature_in;
  logic                     feature_in_en;
  logic                     feature_in_ready;
  logic                     eng_start;
  logic [TPL_W-1:0]         eng_tpl_sel;
  logic signed [FEAT_W-1:0] eng_feature;
  logic                     eng_feature_en;
  logic [DIST_W-1:0]        eng_dist;
  logic                     eng_dist_v;

  modport master (
    input  feature_in, feature_in_en, eng_dist, eng_dist_v,
    output feature_in_ready, eng_start, eng_tpl_sel, eng_feature, eng_feature_en
  );

  modport slave (
    output feature_in, feature_in_en, eng_dist, eng_dist_v,
    input  feature_in_ready, eng_start, eng_tpl_sel, eng_feature, eng_feature_en
  );

endinterface

// File: rtl/recog_frame_buf.sv
// rtl/recog_frame_buf.sv - one-frame feature store, simple dual port with registered read
module recog_frame_buf #(
  parameter int DEPTH = 192,
  parameter int WIDTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic signed [WIDTH-1:0] rd_data
);

  // No reset on the array or read register so the store maps onto block RAM.
  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/recog_match_scheduler.sv
// rtl/recog_match_scheduler.sv - replays one feature frame per template and picks the nearest class
module recog_match_scheduler
  import recog_match_scheduler_pkg::*;
#(
  parameter int Dlength = 192,
  parameter int NUM_TPL = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  recog_match_scheduler_if.master bus,
  input  logic [DIST_W-1:0]       reject_thr,
  output logic [TPL_W-1:0]        compare_result,
  output logic                    compare_result_v,
  output logic                    reject,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int AW = (Dlength > 1) ? $clog2(Dlength) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(Dlength - 1);
  localparam logic [TPL_W-1:0] LAST_TPL  = TPL_W'(NUM_TPL - 1);
  localparam logic [WW-1:0]    LAST_WAIT = WW'(TIMEOUT - 1);

  state_t                   state;
  logic [AW-1:0]            wr_ptr, rd_ptr, rd_addr;
  logic [TPL_W-1:0]         tpl, min_idx, result_hold;
  logic [WW-1:0]            wait_cnt;
  logic [DIST_W-1:0]        min_dist, thr_latched, cur_dist;
  logic signed [FEAT_W-1:0] rd_data;
  logic                     wr_en, timed_out, dist_done;

  assign bus.feature_in_ready = (state == ST_IDLE) || (state == ST_FILL);
  assign wr_en     = bus.feature_in_ready && bus.feature_in_en;

  // Read runs one word ahead of rd_ptr; START issues address 0 so STREAM has no bubble.
  assign rd_addr   = (state == ST_STREAM && rd_ptr != LAST_ADDR) ? rd_ptr + 1'b1 : '0;

  assign timed_out = (state == ST_WAIT) && !bus.eng_dist_v && (wait_cnt == LAST_WAIT);
  assign dist_done = (state == ST_WAIT) && (bus.eng_dist_v || timed_out);
  assign cur_dist  = bus.eng_dist_v ? bus.eng_dist : DIST_MAX;

  assign bus.eng_start      = (state == ST_START);
  assign bus.eng_tpl_sel    = tpl;
  assign bus.eng_feature_en = (state == ST_STREAM);
  assign bus.eng_feature    = bus.eng_feature_en ? rd_data : '0;

  assign compare_result_v = (state == ST_DECIDE);
  assign compare_result   = compare_result_v ? min_idx : result_hold;
  assign reject           = compare_result_v && (min_dist > thr_latched);

  recog_frame_buf #(.DEPTH(Dlength), .WIDTH(FEAT_W), .AW(AW)) u_frame_buf (
    .clk     (sys_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.feature_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tpl         <= '0;
      wait_cnt    <= '0;
      min_dist    <= '0;
      min_idx     <= '0;
      result_hold <= '0;
      thr_latched <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (bus.feature_in_en && !bus.feature_in_ready) overrun <= 1'b1;
      if (timed_out) timeout_err <= 1'b1;

      case (state)
        ST_IDLE, ST_FILL: begin
          if (wr_en) begin
            if (wr_ptr == LAST_ADDR) begin
              wr_ptr      <= '0;
              tpl         <= '0;
              thr_latched <= reject_thr;
              state       <= ST_START;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              state  <= ST_FILL;
            end
          end
        end
        ST_START: begin
          rd_ptr <= '0;
          state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (rd_ptr == LAST_ADDR) begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        ST_WAIT: begin
          if (dist_done) begin
            // Strict less-than keeps the lowest template index on ties.
            if (tpl == '0 || cur_dist < min_dist) begin
              min_dist <= cur_dist;
              min_idx  <= tpl;
            end
            if (tpl == LAST_TPL) begin
              state <= ST_DECIDE;
            end else begin
              tpl   <= tpl + 1'b1;
              state <= ST_START;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECIDE: begin
          result_hold <= min_idx;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recog_match_scheduler.sv
// tb/tb_recog_match_scheduler.sv - scoreboard bench with engine model and argmin reference
module tb_recog_match_scheduler;
  import recog_match_scheduler_pkg::*;

  localparam int D  = 192;
  localparam int NT = 10;
  localparam int TO = 64;
  localparam int L  = 3;

  typedef struct { logic [3:0] idx; bit rej; } exp_t;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [DIST_W-1:0] reject_thr = '0;
  logic [3:0]        compare_result;
  logic              compare_result_v, reject, overrun, timeout_err;

  recog_match_scheduler_if bus();

  recog_match_scheduler #(.Dlength(D), .NUM_TPL(NT), .TIMEOUT(TO)) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .bus              (bus),
    .reject_thr       (reject_thr),
    .compare_result   (compare_result),
    .compare_result_v (compare_result_v),
    .reject           (reject),
    .overrun          (overrun),
    .timeout_err      (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DIST_W-1:0] dist_tab [NT];
  bit                silent   [NT];
  logic signed [15:0] frame   [D];
  exp_t exp_q[$];
  int   start_cnt = 0, n_en = 0;
  int   last_feat_cyc = 0, last_dv_cyc = 0, last_en_cyc = 0;
  bit   prev_silent = 0, eng_reset = 0, model_ovr = 0, model_to = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Template engine: counts the streamed words, answers L cycles after the last one.
  initial begin : engine
    int phase, sel, gaps, derr, lat, exp_c;
    phase = 0; sel = 0; gaps = 0; derr = 0; lat = 0;
    bus.eng_dist_v = 1'b0;
    bus.eng_dist   = '0;
    forever begin
      @(negedge sys_clk);
      bus.eng_dist_v = 1'b0;
      if (eng_reset) begin
        phase = 0; eng_reset = 0;
        continue;
      end
      if (bus.eng_start === 1'b1) begin
        exp_c = (start_cnt == 0) ? last_feat_cyc + 1 :
                prev_silent      ? last_en_cyc + TO + 1 : last_dv_cyc + 1;
        chk("start_timing", cyc, exp_c);
        chk("tpl_sel", bus.eng_tpl_sel, start_cnt);
        sel = int'(bus.eng_tpl_sel);
        if (sel >= NT) sel = NT - 1;
        start_cnt++; n_en = 0; gaps = 0; derr = 0; phase = 1;
      end else if (phase == 1) begin
        if (bus.eng_feature_en === 1'b1) begin
          if (bus.eng_feature !== frame[n_en]) derr++;
          n_en++;
          if (n_en == D) begin
            last_en_cyc = cyc; lat = 0; phase = 2;
            chk("stream_gaps", gaps, 0);
            chk("stream_data_errors", derr, 0);
          end
        end else begin
          gaps++;
        end
      end else if (phase == 2) begin
        lat++;
        if (lat == L) begin
          prev_silent = silent[sel];
          if (!silent[sel]) begin
            bus.eng_dist   = dist_tab[sel];
            bus.eng_dist_v = 1'b1;
            last_dv_cyc    = cyc;
            chk("tpl_sel_stable", bus.eng_tpl_sel, sel);
          end
          phase = 0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (compare_result_v === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result_idx", compare_result, e.idx);
          chk("reject", reject, e.rej);
          chk("result_timing", cyc, last_dv_cyc + 1);
        end
      end
    end
  end

  task automatic send_frame(input int nfeat, input bit gappy);
    int rdy_err;
    rdy_err = 0;
    for (int i = 0; i < nfeat; i++) begin
      @(negedge sys_clk);
      if (gappy && $urandom_range(0, 3) == 0) begin
        bus.feature_in_en = 1'b0;
        @(negedge sys_clk);
      end
      if (bus.feature_in_ready !== (i < D)) rdy_err++;
      bus.feature_in    = 16'($urandom);
      bus.feature_in_en = 1'b1;
      if (i < D) frame[i] = bus.feature_in;
      if (i == D - 1) last_feat_cyc = cyc;
    end
    @(negedge sys_clk);
    bus.feature_in_en = 1'b0;
    chk("ready_profile", rdy_err, 0);
  endtask

  task automatic run_frame(input int nfeat, input logic [DIST_W-1:0] thr, input bit gappy);
    logic [DIST_W-1:0] d [NT];
    logic [DIST_W-1:0] mn;
    exp_t e;
    int   c;
    for (int t = 0; t < NT; t++) begin
      d[t] = silent[t] ? DIST_MAX : dist_tab[t];
      if (silent[t]) model_to = 1;
    end
    mn = d[0];
    for (int t = 1; t < NT; t++) if (d[t] < mn) mn = d[t];
    e.idx = '0;
    for (int t = NT - 1; t >= 0; t--) if (d[t] == mn) e.idx = 4'(t);
    e.rej = (mn > thr);
    exp_q.push_back(e);
    if (nfeat > D) model_ovr = 1;
    reject_thr = thr;
    start_cnt  = 0;
    send_frame(nfeat, gappy);
    reject_thr = $urandom;
    c = 0;
    while (exp_q.size() != 0 && c < 30000) begin
      @(negedge sys_clk);
      c++;
    end
    chk("result_arrived", exp_q.size(), 0);
    exp_q.delete();
    chk("start_count", start_cnt, NT);
    chk("overrun", overrun, model_ovr);
    chk("timeout_err", timeout_err, model_to);
    repeat (3) @(negedge sys_clk);
    chk("result_hold", compare_result, e.idx);
  endtask

  task automatic reset_checks();
    chk("rst_ready", bus.feature_in_ready, 1);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_eng_feature_en", bus.eng_feature_en, 0);
    chk("rst_eng_feature", bus.eng_feature, 0);
    chk("rst_eng_tpl_sel", bus.eng_tpl_sel, 0);
    chk("rst_compare_result", compare_result, 0);
    chk("rst_compare_result_v", compare_result_v, 0);
    chk("rst_reject", reject, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  task automatic rand_dists(input int hi);
    for (int t = 0; t < NT; t++) begin
      dist_tab[t] = DIST_W'($urandom_range(0, hi));
      silent[t]   = 0;
    end
  endtask

  initial begin : main
    int c;
    bus.feature_in    = '0;
    bus.feature_in_en = 1'b0;
    for (int t = 0; t < NT; t++) begin
      dist_tab[t] = '0;
      silent[t]   = 0;
    end
    repeat (3) @(negedge sys_clk);
    reset_checks();
    sys_rst = 1'b0;

    dist_tab = '{50, 40, 30, 20, 15, 10, 5, 25, 35, 45};
    run_frame(D, 100, 1);

    dist_tab = '{30, 20, 9, 15, 12, 40, 11, 9, 22, 33};
    run_frame(D, 9, 0);

    dist_tab = '{1500, 1200, 1000, 3000, 1001, 2000, 1100, 1000, 4000, 1300};
    run_frame(D, 999, 1);

    rand_dists(50);
    run_frame(200, 25, 0);

    rand_dists(20);
    dist_tab[4] = 0;
    silent[4]   = 1;
    run_frame(D, 10, 0);
    silent[4]   = 0;

    rand_dists(30);
    reject_thr = 1000;
    start_cnt  = 0;
    send_frame(D, 0);
    c = 0;
    while (!(start_cnt >= 4 && n_en >= 50) && c < 20000) begin
      @(negedge sys_clk);
      c++;
    end
    chk("reached_mid_stream", (start_cnt >= 4 && n_en >= 50), 1);
    eng_reset = 1;
    sys_rst   = 1'b1;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    reset_checks();
    model_ovr = 0;
    model_to  = 0;
    repeat (2 * D) @(negedge sys_clk);

    dist_tab = '{50, 40, 30, 20, 15, 10, 5, 25, 35, 45};
    run_frame(D, 100, 0);

    for (int k = 0; k < 2; k++) begin
      rand_dists(15);
      run_frame(D, DIST_W'($urandom_range(0, 15)), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
